// File: rtl/crc_stream_param.sv
// ---------------------------------------------------------------------------
// crc_stream_param
// Streaming CRC generator with valid/ready handshakes on both sides. Each
// frame is forwarded unchanged with one cycle of latency, then the final CRC
// is appended as CRC_W/DATA_W trailing words.
//
// Optional feature macro: CRC_CHECK_EN
//   Defined   : receiver mode. The frame already carries its CRC, so nothing
//               is appended. crc_chk_valid pulses the cycle after the in_last
//               beat and crc_ok reports whether the frame CRC equals RESIDUE.
//   Undefined : generator only; crc_ok/crc_chk_valid ports are absent.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_data/valid/last    upstream word, qualifier, end-of-frame marker
//   in_ready              block accepts an input word this cycle
//   out_data/valid/last   downstream word (data or CRC), qualifier, final word
//   out_ready             downstream accepts
//   crc_value             final CRC of the last completed frame
//   crc_done              one-cycle pulse when crc_value updates
//   crc_ok, crc_chk_valid check result and its strobe (CRC_CHECK_EN only)
// ---------------------------------------------------------------------------
module crc_stream_param #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned CRC_W       = 32,
  parameter logic [31:0] POLY        = 32'h04C11DB7,
  parameter logic [31:0] INIT        = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
  parameter bit          REFLECT_IN  = 1'b1,
  parameter bit          REFLECT_OUT = 1'b1,
  parameter logic [31:0] RESIDUE     = 32'h2144DF1C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  crc_value,
  output logic              crc_done
`ifdef CRC_CHECK_EN
  ,
  output logic              crc_ok,
  output logic              crc_chk_valid
`endif
);

  localparam int unsigned NW    = CRC_W / DATA_W;
  localparam int unsigned CNT_W = $clog2(NW + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_APPEND = 2'd2;

  // One word through DATA_W unrolled serial CRC steps.
  function automatic logic [CRC_W-1:0] f_crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             b;
    logic             fb;
    c = crc;
    for (int i = 0; i < DATA_W; i++) begin
      b  = REFLECT_IN ? data[i] : data[DATA_W-1-i];
      fb = c[CRC_W-1] ^ b;
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY[CRC_W-1:0] : {CRC_W{1'b0}});
    end
    return c;
  endfunction

  // Output transform: optional bit reversal, then final XOR.
  function automatic logic [CRC_W-1:0] f_final(input logic [CRC_W-1:0] crc);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) begin
      r[i] = crc[CRC_W-1-i];
    end
    if (!REFLECT_OUT) begin
      r = crc;
    end
    return r ^ XOR_OUT[CRC_W-1:0];
  endfunction

  logic [1:0]        r_state;
  logic [CRC_W-1:0]  r_crc;
  logic [CRC_W-1:0]  r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic [CRC_W-1:0]  r_crc_value;
  logic              r_crc_done;

  logic [1:0]        w_state_nxt;
  logic [CRC_W-1:0]  w_crc_nxt;
  logic [CRC_W-1:0]  w_shift_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_out_data_nxt;
  logic              w_out_valid_nxt;
  logic              w_out_last_nxt;
  logic [CRC_W-1:0]  w_crc_value_nxt;
  logic              w_crc_done_nxt;

  logic              w_out_free;
  logic              w_in_ready;
  logic              w_in_beat;
  logic [CRC_W-1:0]  w_crc_upd;
  logic [CRC_W-1:0]  w_final;

`ifdef CRC_CHECK_EN
  logic              r_crc_ok;
  logic              r_chk_valid;
  logic              w_crc_ok_nxt;
  logic              w_chk_valid_nxt;
`else
  logic              w_unused_residue;
  assign w_unused_residue = ^RESIDUE;
`endif

  // Output register can take a new word when empty or being drained.
  assign w_out_free = ~r_out_valid | out_ready;
  assign w_in_ready = ~rst & (r_state != S_APPEND) & w_out_free;
  assign w_in_beat  = in_valid & w_in_ready;

  // The first word of a frame is seeded from INIT rather than the register.
  assign w_crc_upd  = f_crc_step((r_state == S_IDLE) ? INIT[CRC_W-1:0] : r_crc, in_data);
  assign w_final    = f_final(w_crc_upd);

  // Next-state and datapath decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_crc_nxt       = r_crc;
    w_shift_nxt     = r_shift;
    w_cnt_nxt       = r_cnt;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid & ~out_ready;
    w_out_last_nxt  = r_out_last;
    w_crc_value_nxt = r_crc_value;
    w_crc_done_nxt  = 1'b0;
`ifdef CRC_CHECK_EN
    w_crc_ok_nxt    = r_crc_ok;
    w_chk_valid_nxt = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DATA: begin
        if (w_in_beat) begin
          w_crc_nxt       = w_crc_upd;
          w_out_data_nxt  = in_data;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = 1'b0;
          w_state_nxt     = S_DATA;
          if (in_last) begin
            w_crc_value_nxt = w_final;
            w_crc_done_nxt  = 1'b1;
`ifdef CRC_CHECK_EN
            // Receiver: the last forwarded word is the frame's final CRC word.
            w_out_last_nxt  = 1'b1;
            w_state_nxt     = S_IDLE;
            w_crc_nxt       = INIT[CRC_W-1:0];
            w_chk_valid_nxt = 1'b1;
            w_crc_ok_nxt    = (w_final == RESIDUE[CRC_W-1:0]);
`else
            w_shift_nxt     = w_final;
            w_cnt_nxt       = '0;
            w_state_nxt     = S_APPEND;
`endif
          end
        end
      end
      S_APPEND: begin
        if (w_out_free) begin
          if (r_cnt < CNT_W'(NW)) begin
            w_out_data_nxt  = REFLECT_OUT ? r_shift[DATA_W-1:0] : r_shift[CRC_W-1 -: DATA_W];
            w_shift_nxt     = REFLECT_OUT ? (r_shift >> DATA_W) : (r_shift << DATA_W);
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = (r_cnt == CNT_W'(NW - 1));
            w_cnt_nxt       = r_cnt + CNT_W'(1);
          end else begin
            // All CRC words loaded; the held last word is leaving now.
            w_state_nxt = S_IDLE;
            w_crc_nxt   = INIT[CRC_W-1:0];
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_crc       <= INIT[CRC_W-1:0];
      r_shift     <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_crc_value <= '0;
      r_crc_done  <= 1'b0;
`ifdef CRC_CHECK_EN
      r_crc_ok    <= 1'b0;
      r_chk_valid <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_crc       <= w_crc_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_crc_value <= w_crc_value_nxt;
      r_crc_done  <= w_crc_done_nxt;
`ifdef CRC_CHECK_EN
      r_crc_ok    <= w_crc_ok_nxt;
      r_chk_valid <= w_chk_valid_nxt;
`endif
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign crc_value = r_crc_value;
  assign crc_done  = r_crc_done;
`ifdef CRC_CHECK_EN
  assign crc_ok        = r_crc_ok;
  assign crc_chk_valid = r_chk_valid;
`endif

endmodule
